// File: rtl/full_adder_bist_if.sv
// Stimulus/response link between the BIST engine (master) and the 1-bit
// full adder under test (slave).
interface full_adder_bist_if;
  logic dut_x;
  logic dut_y;
  logic dut_cin;
  logic dut_s;
  logic dut_cout;

  modport master (output dut_x, dut_y, dut_cin, input dut_s, dut_cout);
  modport slave  (input dut_x, dut_y, dut_cin, output dut_s, dut_cout);
endinterface

// File: rtl/full_adder_bist.sv
// Built-in self-test engine for a 1-bit full adder: sweeps all 8 input vectors,
// counts mismatches, latches the first failing vector. Option: FA_BIST_SIG_EN adds an 8-bit MISR.
module full_adder_bist #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  full_adder_bist_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        err_count,
  output logic [2:0]        first_fail
`ifdef FA_BIST_SIG_EN
  ,
  output logic [7:0]        sig
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e     state_q;
  logic [2:0] vec_idx_q;
  logic [2:0] drv_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_count_q;
  logic [2:0] first_fail_q;

  logic [1:0] exp_sum;
  logic       mismatch;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    exp_sum  = {1'b0, drv_q[2]} + {1'b0, drv_q[1]} + {1'b0, drv_q[0]};
    mismatch = ({bus.dut_cout, bus.dut_s} != exp_sum);
  end

`ifdef FA_BIST_SIG_EN
  logic [7:0] sig_q;
  logic [7:0] sig_d;

  always_comb begin
    sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]}
          ^ {6'b0, bus.dut_cout, bus.dut_s};
  end

  assign sig = sig_q;
`endif

  // NOTE: reset is synchronous, so rst is sampled on the clock edge and is
  // deliberately absent from the sensitivity list.
  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others, matching flip-flop behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_idx_q    <= '0;
      drv_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
`ifdef FA_BIST_SIG_EN
      sig_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_count_q  <= '0;
            pass_q       <= 1'b0;
            first_fail_q <= '0;
            vec_idx_q    <= '0;
            busy_q       <= 1'b1;
`ifdef FA_BIST_SIG_EN
            sig_q        <= 8'hFF;
`endif
            state_q      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          drv_q   <= vec_idx_q;
          cnt_q   <= 4'(SETTLE_CYC - 1);
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) state_q <= S_CHECK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count_q <= err_count_q + 4'd1;
            if (err_count_q == 4'd0) first_fail_q <= vec_idx_q;
          end
`ifdef FA_BIST_SIG_EN
          sig_q <= sig_d;
`endif
          if (vec_idx_q == 3'd7) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            vec_idx_q <= vec_idx_q + 3'd1;
            state_q   <= S_DRIVE;
          end
        end
        S_DONE: begin
          // err_count_q already includes the final CHECK by this edge
          done_q  <= 1'b1;
          pass_q  <= (err_count_q == 4'd0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_x   = drv_q[2];
  assign bus.dut_y   = drv_q[1];
  assign bus.dut_cin = drv_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_count_q;
  assign first_fail  = first_fail_q;

endmodule

// File: tb/tb_full_adder_bist.sv
// Scoreboard bench for full_adder_bist: a fault-injectable adder model feeds the
// DUT, an arithmetic reference predicts each run, and a monitor checks on done.
module tb_full_adder_bist;

  localparam int LAT1 = 8 * (1 + 2) + 1;
  localparam int LAT3 = 8 * (3 + 2) + 1;

  typedef struct {
    logic [3:0] err;
    logic [2:0] ff;
    logic       pass;
    logic [7:0] sig;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  int   mode = 0;  // 0 good, 1 cout stuck-0, 2 s inverted, 3 s stuck-1
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       busy, done, pass, busy3, done3, pass3;
  logic [3:0] err_count, err_count3;
  logic [2:0] first_fail, first_fail3;
  logic [7:0] sig, sig3;

  full_adder_bist_if ifc ();
  full_adder_bist_if ifc3 ();

  assign ifc.dut_s    = (mode == 2) ? ~(ifc.dut_x ^ ifc.dut_y ^ ifc.dut_cin)
                      : (mode == 3) ? 1'b1
                      : (ifc.dut_x ^ ifc.dut_y ^ ifc.dut_cin);
  assign ifc.dut_cout = (mode == 1) ? 1'b0
                      : ((ifc.dut_x & ifc.dut_y) | (ifc.dut_x & ifc.dut_cin) | (ifc.dut_y & ifc.dut_cin));
  assign ifc3.dut_s    = ifc3.dut_x ^ ifc3.dut_y ^ ifc3.dut_cin;
  assign ifc3.dut_cout = (ifc3.dut_x & ifc3.dut_y) | (ifc3.dut_x & ifc3.dut_cin) | (ifc3.dut_y & ifc3.dut_cin);

`ifndef FA_BIST_SIG_EN
  assign sig  = 8'h00;
  assign sig3 = 8'h00;
`endif

  full_adder_bist u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (ifc.master),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
`ifdef FA_BIST_SIG_EN
    ,
    .sig        (sig)
`endif
  );

  full_adder_bist #(.SETTLE_CYC(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .bus        (ifc3.master),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_count  (err_count3),
    .first_fail (first_fail3)
`ifdef FA_BIST_SIG_EN
    ,
    .sig        (sig3)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb_q[$];
  exp_t last;
  exp_t mon_e;
  int   last_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a full sweep yields for a given adder fault, from plain arithmetic.
  function automatic exp_t model_run(input int m, input int acc);
    exp_t e;
    logic [7:0] msr;
    logic rs, rc;
    bit   first;
    int   n;
    e.err = 0; e.ff = 0; e.acc = acc;
    msr = 8'hFF; first = 1'b1;
    for (int v = 0; v < 8; v++) begin
      n  = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
      rs = logic'(n % 2);
      rc = logic'(n / 2);
      if (m == 1) rc = 1'b0;
      if (m == 2) rs = ~rs;
      if (m == 3) rs = 1'b1;
      if (rs != logic'(n % 2) || rc != logic'(n / 2)) begin
        if (first) e.ff = 3'(v);
        first = 1'b0;
        e.err = e.err + 4'd1;
      end
      msr = {msr[6:0], msr[7] ^ msr[5] ^ msr[4] ^ msr[3]} ^ {6'b0, rc, rs};
    end
    e.pass = (e.err == 0);
`ifdef FA_BIST_SIG_EN
    e.sig = msr;
`else
    e.sig = 8'h00;
`endif
    return e;
  endfunction

  // Monitor: every done pulse consumes one prediction.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_latency", 32'(cyc - mon_e.acc), 32'(LAT1));
        check("err_count", 32'(err_count), 32'(mon_e.err));
        check("pass", 32'(pass), 32'(mon_e.pass));
        check("first_fail", 32'(first_fail), 32'(mon_e.ff));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef FA_BIST_SIG_EN
        check("sig", 32'(sig), 32'(mon_e.sig));
`endif
      end
    end
  end

  task automatic wait_done(input bit spurious, output bit seen);
    int s1, s2;
    s1 = $urandom_range(1, 20);
    s2 = $urandom_range(1, 20);
    seen = 1'b0;
    last_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) last_busy++;
      start = spurious && (i == s1 || i == s2);
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int m, input bit spurious);
    bit seen;
    check("held_err_count", 32'(err_count), 32'(last.err));
    check("held_pass", 32'(pass), 32'(last.pass));
    check("held_first_fail", 32'(first_fail), 32'(last.ff));
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    last  = model_run(m, cyc);
    sb_q.push_back(last);
    wait_done(spurious, seen);
    tick();
  endtask

  initial begin
    bit seen;
    int a3;
    last = '{err: 0, ff: 0, pass: 0, sig: 0, acc: 0};
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vec", 32'({ifc.dut_x, ifc.dut_y, ifc.dut_cin}), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    tick();

    run(0, 1'b0);
    check("busy_cycles", 32'(last_busy), 32'd24);
    check("good_pass", 32'(pass), 32'd1);
    run(1, 1'b0);
    check("sa0_err", 32'(err_count), 32'd4);
    check("sa0_first", 32'(first_fail), 32'd3);
    run(2, 1'b0);
    check("inv_err", 32'(err_count), 32'd8);
    check("inv_first", 32'(first_fail), 32'd0);
    run(0, 1'b1);
    check("reconnect_pass", 32'(pass), 32'd1);

    // Reset mid-run at edge 10 after accept.
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_results", 32'({pass, err_count, first_fail}), 32'd0);
    check("midrst_vec", 32'({ifc.dut_x, ifc.dut_y, ifc.dut_cin}), 32'd0);
    check("midrst_sig", 32'(sig), 32'd0);
    repeat (30) tick();
    check("midrst_idle", 32'(busy), 32'd0);
    last = '{err: 0, ff: 0, pass: 0, sig: 0, acc: 0};
    run(0, 1'b0);
    check("after_rst_pass", 32'(pass), 32'd1);

    // start held through DONE is accepted in the following IDLE cycle.
    mode  = 3;
    start = 1'b1;
    tick();
    sb_q.push_back(model_run(3, cyc));
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) check("hold_timeout", 32'd0, 32'd1);
    mode = 0;
    tick();
    start = 1'b0;
    check("hold_accept_busy", 32'(busy), 32'd1);
    last = model_run(0, cyc);
    sb_q.push_back(last);
    wait_done(1'b0, seen);
    tick();

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 4)) tick();
      run(int'($urandom_range(0, 3)), 1'b1);
    end

    // Settle scaling on the SETTLE_CYC=3 instance.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    a3 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done3) begin seen = 1'b1; break; end
    end
    check("s3_done_seen", 32'(seen), 32'd1);
    check("s3_latency", 32'(cyc - a3), 32'(LAT3));
    check("s3_pass", 32'(pass3), 32'd1);
    check("s3_err", 32'(err_count3), 32'd0);
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
